// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with sync clear/load, terminal count, wrap pulse and sticky overflow.
// Optional registered Gray-code output enabled by defining MOD_UPDOWN_COUNTER_GRAY_EN.
module mod_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  output logic             ovf,
  output logic [WIDTH-1:0] gray
`else
  output logic             ovf
`endif
);

  // Largest legal count; for MODULUS == 2**WIDTH this is all ones, so wrap is plain binary overflow.
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;

  assign w_at_max  = (r_count == LP_MAX);
  assign w_at_zero = (r_count == '0);
  assign w_tc      = en & ~clr & ~load & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

  always_comb begin
    w_next = r_count;
    if (clr) begin
      w_next = '0;
    end else if (load) begin
      // Out-of-range load values saturate to the top of the sequence.
      w_next = (load_val <= LP_MAX) ? load_val : LP_MAX;
    end else if (en) begin
      if (up_dn) begin
        w_next = w_at_max ? '0 : r_count + 1'b1;
      end else begin
        w_next = w_at_zero ? LP_MAX : r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_tc;
      // A wrap on the same edge wins over ovf_clr; clr wins over both.
      if (clr) begin
        r_ovf <= 1'b0;
      end else if (w_tc) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  logic [WIDTH-1:0] r_gray;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gray <= '0;
    end else begin
      r_gray <= w_next ^ (w_next >> 1);
    end
  end

  assign gray = r_gray;
`endif

  assign count = r_count;
  assign tc    = w_tc;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter (WIDTH=3, MODULUS=6): modular-arithmetic model checked every cycle,
// plus directed sequences with literal expectations.
module tb_mod_updown_counter;

  localparam int W   = 3;
  localparam int MOD = 6;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         ovf_clr;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         ovf;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  logic [W-1:0] gray;
  int           g_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_count = 0;
  bit m_wrap  = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_t;

  logic [4:0] pat [12] = '{5'b11000, 5'b11000, 5'b10000, 5'b11000, 5'b10001, 5'b10000,
                           5'b10000, 5'b10000, 5'b01000, 5'b11010, 5'b10100, 5'b11001};
  int up_exp [7] = '{1, 2, 3, 4, 5, 0, 1};

  mod_updown_counter #(.WIDTH(W), .MODULUS(MOD)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .ovf_clr  (ovf_clr),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    .ovf      (ovf),
    .gray     (gray)
`else
    .ovf      (ovf)
`endif
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_tc();
    return en && !clr && !load && (up_dn ? (m_count == MOD - 1) : (m_count == 0));
  endfunction

  // behavioural model: count lives in Z/MOD, a wrap is a step across the MOD boundary
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 0;
      m_wrap  = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      m_t = model_tc();
      if (clr) begin
        m_count = 0;
        m_wrap  = 1'b0;
        m_ovf   = 1'b0;
      end else begin
        if (load)       m_count = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
        else if (en)    m_count = up_dn ? (m_count + 1) % MOD : (m_count + MOD - 1) % MOD;
        m_wrap = m_t;
        if (m_t)          m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("cmp_count", 32'(count), 32'(m_count));
    chk("cmp_tc",    32'(tc),    32'(model_tc()));
    chk("cmp_wrap",  32'(wrap),  32'(m_wrap));
    chk("cmp_ovf",   32'(ovf),   32'(m_ovf));
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    chk("cmp_gray",  32'(gray),  32'(g_tab[m_count]));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit i_en, input bit i_up, input bit i_clr, input bit i_load,
                       input int i_lv, input bit i_oc);
    en       = i_en;
    up_dn    = i_up;
    clr      = i_clr;
    load     = i_load;
    load_val = W'(i_lv);
    ovf_clr  = i_oc;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_wrap",  32'(wrap),  0);
    chk("rst_ovf",   32'(ovf),   0);
    rst = 1'b1;
    tick();
    chk("hold_after_rst", 32'(count), 0);

    // count up from 0 through the wrap
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      #1 chk("up_tc", 32'(tc), 32'(i == 5));
      tick();
      chk("up_count", 32'(count), 32'(up_exp[i]));
      chk("up_wrap",  32'(wrap),  32'(i == 5));
      chk("up_ovf",   32'(ovf),   32'(i >= 5));
    end

    // count down from 1 through the wrap
    drive(1, 0, 0, 0, 0, 0);
    #1 chk("dn_tc1", 32'(tc), 0);
    tick();
    chk("dn_count0", 32'(count), 0);
    chk("dn_wrap0",  32'(wrap),  0);
    #1 chk("dn_tc0", 32'(tc), 1);
    tick();
    chk("dn_count5", 32'(count), 5);
    chk("dn_wrap5",  32'(wrap),  1);
    tick();
    chk("dn_count4", 32'(count), 4);
    chk("dn_wrap4",  32'(wrap),  0);
    chk("dn_ovf4",   32'(ovf),   1);

    // ovf_clr alone, then ovf_clr colliding with a wrap
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("oc_ovf", 32'(ovf), 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) tick();
    chk("oc_count0", 32'(count), 0);
    drive(1, 0, 0, 0, 0, 1);
    tick();
    chk("oc_hit_count", 32'(count), 5);
    chk("oc_hit_wrap",  32'(wrap),  1);
    chk("oc_hit_ovf",   32'(ovf),   1);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("oc_late_ovf",  32'(ovf),  0);
    chk("oc_late_wrap", 32'(wrap), 0);

    // load: saturation and no wrap on load
    drive(1, 1, 0, 1, 7, 0);
    #1 chk("ld_tc", 32'(tc), 0);
    tick();
    chk("ld7_count", 32'(count), 5);
    chk("ld7_wrap",  32'(wrap),  0);
    drive(1, 1, 0, 1, 3, 0);
    tick();
    chk("ld3_count", 32'(count), 3);
    drive(0, 0, 0, 1, 6, 0);
    tick();
    chk("ld6_count", 32'(count), 5);
    drive(1, 1, 0, 1, 0, 0);
    tick();
    chk("ld0_count", 32'(count), 0);
    chk("ld0_wrap",  32'(wrap),  0);

    // clr beats load and en, and clears ovf
    drive(0, 1, 0, 1, 5, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0);
    tick();
    chk("pre_clr_ovf", 32'(ovf), 1);
    drive(0, 1, 0, 1, 5, 0);
    tick();
    drive(1, 1, 1, 1, 2, 0);
    #1 chk("clr_tc", 32'(tc), 0);
    tick();
    chk("clr_count", 32'(count), 0);
    chk("clr_wrap",  32'(wrap),  0);
    chk("clr_ovf",   32'(ovf),   0);

    // mixed directed vectors {en,up_dn,clr,load,ovf_clr}, direction flipping freely
    for (int i = 0; i < 12; i++) begin
      drive(pat[i][4], pat[i][3], pat[i][2], pat[i][1], i, pat[i][0]);
      tick();
    end

    // asynchronous reset mid-count, with a pending load aborted
    drive(0, 1, 0, 1, 5, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 1, 4, 0);
    tick();
    chk("ar_pre_count", 32'(count), 4);
    chk("ar_pre_ovf",   32'(ovf),   1);
    drive(1, 1, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_wrap",  32'(wrap),  0);
    chk("ar_ovf",   32'(ovf),   0);
    drive(1, 1, 0, 1, 3, 0);
    tick();
    chk("ar_load_abort", 32'(count), 0);
    drive(1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk("ar_resume", 32'(count), 1);
    tick();
    chk("ar_resume2", 32'(count), 2);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 3: counter width in bits, range 2..16.
REQ-002 SHALL have parameter MODULUS, default 8: count sequence length, range 2..2^WIDTH.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: count enable.
REQ-006 SHALL have port up_dn, input, 1: direction; 1 = up, 0 = down.
REQ-007 SHALL have port clr, input, 1: synchronous clear to 0.
REQ-008 SHALL have port load, input, 1: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH: value to load.
REQ-010 SHALL have port ovf_clr, input, 1: clears the sticky overflow flag.
REQ-011 SHALL have port count, output, WIDTH: registered count value.
REQ-012 SHALL have port tc, output, 1: combinational terminal-count indication.
REQ-013 SHALL have port wrap, output, 1: registered one-cycle wrap pulse.
REQ-014 SHALL have port ovf, output, 1: sticky flag, set by any wrap.

Function
REQ-015 SHALL be fully synchronous to clk: no derived clocks, no ripple stages.
REQ-016 SHALL apply per-edge priority clr > load > en; with none asserted, count holds.
REQ-017 SHALL, on clr, set count = 0 and wrap = 0, and clear ovf, regardless of en, load and ovf_clr.
REQ-018 SHALL, on load, set count = load_val when load_val < MODULUS; otherwise count = MODULUS-1.
REQ-019 SHALL never generate wrap on a load, even when the loaded value is 0 or MODULUS-1.
REQ-020 SHALL, on en with up_dn = 1, increment count; from MODULUS-1 the next value is 0.
REQ-021 SHALL, on en with up_dn = 0, decrement count; from 0 the next value is MODULUS-1.
REQ-022 SHALL drive tc = en & ~clr & ~load & ((up_dn & count == MODULUS-1) | (~up_dn & count == 0)).
REQ-023 SHALL assert wrap for exactly the one cycle after every edge where tc was 1; wrap is 0 otherwise.
REQ-024 SHALL set ovf on the same edge wrap is registered high.
REQ-025 SHALL hold ovf until clr, or until ovf_clr is sampled high.
REQ-026 SHALL give set priority over ovf_clr when both occur on the same edge: ovf stays 1.
REQ-027 SHALL let up_dn change on any cycle; the new direction takes effect at the next enabled edge.
REQ-028 SHALL have 1-cycle latency from any sampled control input to count.
REQ-029 SHALL, when MODULUS = 2^WIDTH, wrap by natural binary overflow, with identical tc/wrap behaviour.

Reset
REQ-030 SHALL, when rst = 0, immediately force count = 0, wrap = 0, ovf = 0 (and gray = 0 when present), independent of clk.
REQ-031 SHALL, on rst deassertion, resume counting at the first rising clk edge with en = 1.
REQ-032 SHALL abort any load or clear pending in the same cycle when reset is asserted mid-operation.

Configuration
REQ-033 SHALL, with macro MOD_UPDOWN_COUNTER_GRAY_EN defined, add output port gray, WIDTH bits.
REQ-034 SHALL register gray as the Gray code of count's next value, so that gray == count ^ (count >> 1) on every cycle.
REQ-035 SHALL, without MOD_UPDOWN_COUNTER_GRAY_EN, omit the gray port and logic; all other behaviour is identical.

Verification (WIDTH=3, MODULUS=6)
REQ-036 SHALL check: rst low mid-count (count=4) -> count=0, wrap=0, ovf=0 asynchronously, before the next clk edge.
REQ-037 SHALL check: en=1, up_dn=1 from 0 for 7 edges -> count 1,2,3,4,5,0,1; tc=1 while count=5; wrap=1 in the cycle count=0; ovf=1 from then on.
REQ-038 SHALL check: en=1, up_dn=0 from count=1 -> count 0, then 5; tc=1 while count=0; wrap pulse 1 cycle.
REQ-039 SHALL check: load=1, load_val=7 with en=1 -> count=5, wrap=0; then load_val=3 -> count=3.
REQ-040 SHALL check: clr, load and en all 1 at count=5 -> count=0, wrap=0, ovf cleared.
REQ-041 SHALL check: ovf_clr=1 on the same edge a wrap is registered -> ovf=1; ovf_clr=1 on a later edge -> ovf=0. With MOD_UPDOWN_COUNTER_GRAY_EN defined, gray tracks count as 000,001,011,010,110,111.
